// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - ALU control decoder with a one-bit-per-cycle shift sequencer
// Optional feature macro: ALU_CTRL_ILLEGAL_TRAP_EN (trap ALUOp=1 funcCode>9 as illegal)
module alu_ctrl_seq #(
    parameter int FUNC_W  = 5,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               ALUOp,
    input  logic [FUNC_W-1:0]  funcCode,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               isLog,
    output logic               dir,
    output logic [2:0]         opSwitch,
    output logic [2:0]         flagSwitch,
    output logic               shift_step,
    output logic               busy,
    output logic               illegal
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state;
    state_t             stateNext;
    logic [SHAMT_W-1:0] shiftCnt;
    logic               accept;

    logic               decIsLog;
    logic               decDir;
    logic               decShift;
    logic               decIllegal;
    logic [2:0]         decOp;
    logic [2:0]         decFlag;

    assign accept = in_valid && in_ready;

    // Combinational decode of the request; only captured on accept.
    always_comb begin
        decOp      = 3'd0;
        decFlag    = 3'b001;
        decIsLog   = 1'b0;
        decDir     = 1'b0;
        decShift   = 1'b0;
        decIllegal = 1'b0;
        if (ALUOp) begin
            case (funcCode)
                FUNC_W'(0): begin
                    decOp   = 3'd0;
                    decFlag = 3'b001;
                end
                FUNC_W'(1): begin
                    decOp   = 3'd1;
                    decFlag = 3'b010;
                end
                FUNC_W'(2): begin
                    decOp   = 3'd2;
                    decFlag = 3'b000;
                end
                FUNC_W'(3): begin
                    decOp   = 3'd3;
                    decFlag = 3'b000;
                end
                FUNC_W'(4), FUNC_W'(7): begin
                    decOp    = 3'd4;
                    decFlag  = 3'b100;
                    decIsLog = 1'b1;
                    decDir   = 1'b0;
                    decShift = 1'b1;
                end
                FUNC_W'(5), FUNC_W'(8): begin
                    decOp    = 3'd4;
                    decFlag  = 3'b100;
                    decIsLog = 1'b1;
                    decDir   = 1'b1;
                    decShift = 1'b1;
                end
                FUNC_W'(6), FUNC_W'(9): begin
                    decOp    = 3'd4;
                    decFlag  = 3'b100;
                    decIsLog = 1'b0;
                    decDir   = 1'b1;
                    decShift = 1'b1;
                end
                default: begin
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
                    decOp      = 3'b111;
                    decFlag    = 3'b000;
                    decIllegal = 1'b1;
`else
                    decOp      = 3'd0;
                    decFlag    = 3'b001;
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    stateNext = (decShift && (shamt != '0)) ? SHIFT : HOLD;
                end
            end
            SHIFT: begin
                // Last strobe is the cycle the counter reads 1, so it never wraps.
                if (shiftCnt == SHAMT_W'(1)) begin
                    stateNext = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = 1'b0;
        busy       = 1'b0;
        shift_step = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE:  in_ready = 1'b1;
            SHIFT: begin
                busy       = 1'b1;
                shift_step = 1'b1;
            end
            HOLD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shiftCnt   <= '0;
            isLog      <= 1'b0;
            dir        <= 1'b0;
            opSwitch   <= 3'd0;
            flagSwitch <= 3'd0;
        end else if (accept) begin
            shiftCnt   <= decShift ? shamt : '0;
            isLog      <= decIsLog;
            dir        <= decDir;
            opSwitch   <= decOp;
            flagSwitch <= decFlag;
        end else if (state == SHIFT) begin
            shiftCnt   <= shiftCnt - SHAMT_W'(1);
        end
    end

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal <= 1'b0;
        end else if (accept && decIllegal) begin
            illegal <= 1'b1;
        end
    end
`else
    // decIllegal is never set in this build, so illegal is tied low.
    assign illegal = decIllegal;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb/tb_alu_ctrl_seq.sv - scoreboard bench for alu_ctrl_seq
// Honours ALU_CTRL_ILLEGAL_TRAP_EN when deciding expected illegal-op results.
module tb_alu_ctrl_seq;

    localparam int FUNC_W  = 5;
    localparam int SHAMT_W = 5;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               ALUOp = 1'b0;
    logic [FUNC_W-1:0]  funcCode = '0;
    logic [SHAMT_W-1:0] shamt = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic               isLog;
    logic               dir;
    logic [2:0]         opSwitch;
    logic [2:0]         flagSwitch;
    logic               shift_step;
    logic               busy;
    logic               illegal;

    alu_ctrl_seq #(.FUNC_W(FUNC_W), .SHAMT_W(SHAMT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .funcCode(funcCode), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready),
        .isLog(isLog), .dir(dir), .opSwitch(opSwitch), .flagSwitch(flagSwitch),
        .shift_step(shift_step), .busy(busy), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       isLog;
        logic       dir;
        logic [2:0] op;
        logic [2:0] flag;
        logic [7:0] steps;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   failures = 0;
    logic expIllegal = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic aluop, input int fc, input int sh);
        exp_t e;
        e.isLog = 1'b0;
        e.dir   = 1'b0;
        e.op    = 3'd0;
        e.flag  = 3'b001;
        e.steps = 8'd0;
        if (aluop) begin
            case (fc)
                0: ;
                1: begin e.op = 3'd1; e.flag = 3'b010; end
                2: begin e.op = 3'd2; e.flag = 3'b000; end
                3: begin e.op = 3'd3; e.flag = 3'b000; end
                4, 7: begin e.op = 3'd4; e.flag = 3'b100; e.isLog = 1'b1; end
                5, 8: begin e.op = 3'd4; e.flag = 3'b100; e.isLog = 1'b1; e.dir = 1'b1; end
                6, 9: begin e.op = 3'd4; e.flag = 3'b100; e.dir = 1'b1; end
                default: begin
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
                    e.op = 3'b111; e.flag = 3'b000;
`endif
                end
            endcase
        end
        if (e.op == 3'd4) e.steps = 8'(sh);
        return e;
    endfunction

    function automatic logic isIllegalReq(input logic aluop, input int fc);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
        return aluop && (fc > 9);
`else
        return 1'b0 & aluop & (fc > 9);
`endif
    endfunction

    task automatic doOp(input logic aluop, input int fc, input int sh, input int holdCyc);
        exp_t e;
        exp_t sb;
        int   lat;
        int   steps;
        e = model(aluop, fc, sh);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        ALUOp    = aluop;
        funcCode = fc[FUNC_W-1:0];
        shamt    = sh[SHAMT_W-1:0];
        expQ.push_back(e);
        if (isIllegalReq(aluop, fc)) expIllegal = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        ALUOp    = ~aluop;
        funcCode = FUNC_W'(3);
        shamt    = '1;
        lat   = 1;
        steps = 0;
        while (!out_valid && lat < 100) begin
            if (shift_step) steps++;
            @(negedge clk);
            lat++;
        end
        check($sformatf("latency f%0d s%0d", fc, sh), lat, 32'(e.steps) + 1);
        check($sformatf("strobes f%0d s%0d", fc, sh), steps, 32'(e.steps));
        check("no_step_in_hold", shift_step, 0);
        if (expQ.size() == 0) begin
            check("sb_underflow", 1, 0);
            return;
        end
        sb = expQ.pop_front();
        check($sformatf("decode f%0d", fc), {isLog, dir, opSwitch, flagSwitch},
              {sb.isLog, sb.dir, sb.op, sb.flag});
        check("illegal", illegal, expIllegal);
        for (int i = 0; i < holdCyc; i++) begin
            in_valid = 1'b1;
            ALUOp    = 1'b1;
            funcCode = FUNC_W'(1);
            @(negedge clk);
            check("hold_stable", {out_valid, in_ready, busy, isLog, dir, opSwitch, flagSwitch},
                  {3'b101, sb.isLog, sb.dir, sb.op, sb.flag});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release", {out_valid, in_ready, busy}, 3'b010);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int steps;
        int cyc;
        int extra;
        #20 reset = 1'b0;
        #55 reset = 1'b1;
        #10;
        check("reset_vals",
              {in_ready, out_valid, shift_step, busy, illegal, isLog, dir, opSwitch, flagSwitch},
              {1'b1, 4'b0000, 2'b00, 3'd0, 3'd0});
        #20 reset = 1'b0;
        @(negedge clk);
        check("post_reset_vals",
              {in_ready, out_valid, shift_step, busy, illegal, isLog, dir, opSwitch, flagSwitch},
              {1'b1, 4'b0000, 2'b00, 3'd0, 3'd0});

        doOp(1'b0, 4, 3, 0);
        doOp(1'b1, 6, 3, 0);
        doOp(1'b1, 5, 0, 5);
        doOp(1'b1, 0, 7, 0);
        doOp(1'b1, 1, 2, 1);
        doOp(1'b1, 2, 0, 0);
        doOp(1'b1, 3, 1, 0);
        doOp(1'b1, 4, 2, 0);
        doOp(1'b1, 7, 1, 0);
        doOp(1'b1, 9, 4, 2);
        doOp(1'b1, 15, 3, 0);
        doOp(1'b1, 8, 2, 0);

        for (int i = 0; i < 3; i++) begin
            out_ready = 1'b1;
            @(negedge clk);
            check("idle_out_ready", {out_valid, in_ready, busy}, 3'b010);
        end
        out_ready = 1'b0;

        @(negedge clk);
        in_valid = 1'b1;
        ALUOp    = 1'b1;
        funcCode = FUNC_W'(8);
        shamt    = SHAMT_W'(31);
        expQ.push_back(model(1'b1, 8, 31));
        @(negedge clk);
        in_valid = 1'b0;
        steps = 0;
        cyc   = 0;
        while (steps < 10 && cyc < 100) begin
            if (shift_step) steps++;
            if (steps < 10) begin
                @(negedge clk);
                cyc++;
            end
        end
        check("abort_strobes", steps, 10);
        #2 reset = 1'b1;
        #1;
        check("abort_async", {shift_step, out_valid, busy, in_ready, illegal}, 5'b00010);
        expQ.delete();
        expIllegal = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (shift_step || out_valid) extra++;
        end
        check("abort_quiet", extra, 0);
        check("illegal_cleared", illegal, 0);

        doOp(1'b1, 8, 31, 0);
        doOp(1'b1, 6, 31, 1);
        check("sb_empty", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
